// File: rtl/perf_ctrl.sv
// Control front-end for the execution performance counter: SPR decode,
// trigger strobes, start/run/end sequencing, elapsed-cycle tracking and auto-stop.
module perf_ctrl #(
    parameter int SPR_AW  = 2,
    parameter int LIMIT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spr_cs,
    input  logic              spr_write,
    input  logic [SPR_AW-1:0] spr_addr,
    input  logic [31:0]       spr_dat_i,
    output logic [31:0]       spr_dat_o,
    input  logic              trig_start,
    input  logic              trig_end,
    output logic              perf_start,
    output logic              en,
    output logic              perf_end,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_END, S_DONE} state_t;

    state_t               state, state_nx;
    logic                 auto_stop, trig_en, auto_stopped;
    logic [LIMIT_W-1:0]   limit, elapsed;
    logic                 wr_ctrl, wr_limit, rd_en;
    logic                 go, halt, limit_hit;

    assign wr_ctrl  = spr_cs & spr_write & (spr_addr == SPR_AW'(0));
    assign wr_limit = spr_cs & spr_write & (spr_addr == SPR_AW'(2));
    assign rd_en    = spr_cs & ~spr_write;

    assign go        = (wr_ctrl & spr_dat_i[0]) | (trig_en & trig_start);
    assign halt      = (wr_ctrl & spr_dat_i[1]) | (trig_en & trig_end);
    // Compared against LIMIT-1 so the final RUN cycle is the L-th enabled cycle.
    assign limit_hit = auto_stop & (limit != '0) & (elapsed == limit - LIMIT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (go && !halt) state_nx = S_START;
            S_START:        state_nx = halt ? S_END : S_RUN;
            S_RUN:          if (halt || limit_hit) state_nx = S_END;
            S_END:          state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        perf_start = (state == S_START);
        en         = (state == S_RUN);
        perf_end   = (state == S_END);
        busy       = (state == S_START) || (state == S_RUN) || (state == S_END);
        done       = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto_stop <= 1'b0;
            trig_en   <= 1'b0;
            limit     <= '0;
        end else begin
            if (wr_ctrl) begin
                auto_stop <= spr_dat_i[2];
                trig_en   <= spr_dat_i[3];
            end
            if (wr_limit) limit <= spr_dat_i[LIMIT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            elapsed      <= '0;
            auto_stopped <= 1'b0;
        end else if (state == S_START) begin
            elapsed      <= '0;
            auto_stopped <= 1'b0;
        end else if (state == S_RUN) begin
            if (elapsed != '1) elapsed <= elapsed + LIMIT_W'(1);
            // Halt wins over a simultaneous limit hit.
            if (!halt && limit_hit) auto_stopped <= 1'b1;
        end
    end

    always_comb begin
        spr_dat_o = '0;
        if (rd_en) begin
            case (spr_addr)
                SPR_AW'(0): spr_dat_o = {28'b0, trig_en, auto_stop, 2'b00};
                SPR_AW'(1): spr_dat_o = {29'b0, auto_stopped, done, busy};
                SPR_AW'(2): spr_dat_o = 32'(limit);
                SPR_AW'(3): spr_dat_o = 32'(elapsed);
                default:    spr_dat_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_ctrl.sv
// Self-checking bench for perf_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_perf_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spr_cs = 1'b0, spr_write = 1'b0;
    logic [1:0]  spr_addr = '0;
    logic [31:0] spr_dat_i = '0;
    logic [31:0] spr_dat_o;
    logic        trig_start = 1'b0, trig_end = 1'b0;
    logic        perf_start, en, perf_end, busy, done;

    int checks = 0;
    int fails  = 0;

    perf_ctrl #(.SPR_AW(2), .LIMIT_W(32)) dut (
        .clk(clk), .rst(rst), .spr_cs(spr_cs), .spr_write(spr_write),
        .spr_addr(spr_addr), .spr_dat_i(spr_dat_i), .spr_dat_o(spr_dat_o),
        .trig_start(trig_start), .trig_end(trig_end), .perf_start(perf_start),
        .en(en), .perf_end(perf_end), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0=idle 1=start 2=run 3=end 4=done.
    int          m_ph;
    logic        m_auto, m_trig, m_as;
    logic [31:0] m_limit, m_elapsed;
    logic        m_wctrl, m_go, m_halt, m_hit;

    assign m_wctrl = spr_cs && spr_write && spr_addr == 2'd0;
    assign m_go    = (m_wctrl && spr_dat_i[0]) || (m_trig && trig_start);
    assign m_halt  = (m_wctrl && spr_dat_i[1]) || (m_trig && trig_end);
    assign m_hit   = m_auto && m_limit != 0 && m_elapsed + 1 == m_limit;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph <= 0; m_auto <= 0; m_trig <= 0; m_as <= 0;
            m_limit <= 0; m_elapsed <= 0;
        end else begin
            if (m_wctrl) begin
                m_auto <= spr_dat_i[2];
                m_trig <= spr_dat_i[3];
            end
            if (spr_cs && spr_write && spr_addr == 2'd2) m_limit <= spr_dat_i;
            if (m_ph == 0 || m_ph == 4) begin
                if (m_go && !m_halt) m_ph <= 1;
            end else if (m_ph == 1) begin
                m_elapsed <= 0;
                m_as      <= 0;
                m_ph      <= m_halt ? 3 : 2;
            end else if (m_ph == 2) begin
                if (m_elapsed != 32'hFFFF_FFFF) m_elapsed <= m_elapsed + 1;
                if (m_halt) m_ph <= 3;
                else if (m_hit) begin
                    m_ph <= 3;
                    m_as <= 1;
                end
            end else begin
                m_ph <= 4;
            end
        end
    end

    function automatic logic [31:0] exp_rd();
        if (!(spr_cs && !spr_write)) return 32'd0;
        case (spr_addr)
            2'd0:    return {28'd0, m_trig, m_auto, 2'b00};
            2'd1:    return {29'd0, m_as, m_ph == 4, m_ph >= 1 && m_ph <= 3};
            2'd2:    return m_limit;
            default: return m_elapsed;
        endcase
    endfunction

    always @(negedge clk) begin
        chk("m_perf_start", 32'(perf_start), 32'(m_ph == 1));
        chk("m_en",         32'(en),         32'(m_ph == 2));
        chk("m_perf_end",   32'(perf_end),   32'(m_ph == 3));
        chk("m_busy",       32'(busy),       32'(m_ph >= 1 && m_ph <= 3));
        chk("m_done",       32'(done),       32'(m_ph == 4));
        chk("m_spr_dat_o",  spr_dat_o,       exp_rd());
    end

    // Downstream counter stand-in.
    int total;
    always @(posedge clk) begin
        if (perf_start) total <= 0;
        else if (en)    total <= total + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        spr_cs = 1; spr_write = 1; spr_addr = a; spr_dat_i = d;
        tick();
        spr_cs = 0; spr_write = 0; spr_dat_i = '0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        spr_cs = 1; spr_write = 0; spr_addr = a;
        #1;
        chk(name, spr_dat_o, exp);
        spr_cs = 0;
    endtask

    task automatic pulse(input logic s, input logic e);
        trig_start = s; trig_end = e;
        tick();
        trig_start = 0; trig_end = 0;
    endtask

    initial begin
        #2 rst = 0;
        #1;
        chk("rst_en", 32'(en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rd("rst_elapsed", 2'd3, 0);
        rd("rst_limit", 2'd2, 0);
        tick(); tick();
        rst = 1;

        // Triggers
        wr(2'd0, 32'h8);
        pulse(1, 1);
        chk("trig_both_idle_busy", 32'(busy), 0);
        pulse(1, 0);
        chk("trig_start_pulse", 32'(perf_start), 1);
        tick();
        chk("trig_run_en", 32'(en), 1);
        pulse(1, 0);
        chk("trig_restart_ignored_en", 32'(en), 1);
        chk("trig_restart_ignored_ps", 32'(perf_start), 0);
        pulse(0, 1);
        chk("trig_end_pe", 32'(perf_end), 1);
        tick();
        chk("trig_done", 32'(done), 1);
        wr(2'd0, 32'h0);
        pulse(1, 0);
        chk("trig_disabled_ps", 32'(perf_start), 0);
        chk("trig_disabled_done", 32'(done), 1);

        // Manual run: go at N, stop at N+7
        wr(2'd0, 32'h1);
        chk("man_ps", 32'(perf_start), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("man_en", 32'(en), 1);
        end
        wr(2'd0, 32'h2);
        chk("man_pe", 32'(perf_end), 1);
        chk("man_pe_en", 32'(en), 0);
        tick();
        rd("man_elapsed", 2'd3, 6);
        rd("man_status", 2'd1, 32'h2);

        // Auto-stop at LIMIT=5
        wr(2'd2, 32'd5);
        wr(2'd0, 32'h5);
        chk("auto_ps", 32'(perf_start), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("auto_en", 32'(en), 1);
        end
        tick();
        chk("auto_pe", 32'(perf_end), 1);
        chk("auto_pe_en", 32'(en), 0);
        tick();
        rd("auto_elapsed", 2'd3, 5);
        rd("auto_status", 2'd1, 32'h6);
        rd("auto_ctrl", 2'd0, 32'h4);
        chk("auto_total", 32'(total), 5);

        // LIMIT=0 disables auto-stop
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h5);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("lim0_no_pe", 32'(perf_end), 0);
        end
        wr(2'd0, 32'h6);
        chk("lim0_pe", 32'(perf_end), 1);
        tick();
        rd("lim0_elapsed", 2'd3, 100);
        rd("lim0_status", 2'd1, 32'h2);

        // Halt in START
        wr(2'd0, 32'h1);
        wr(2'd0, 32'h2);
        chk("hs_pe", 32'(perf_end), 1);
        chk("hs_en", 32'(en), 0);
        tick();
        rd("hs_elapsed", 2'd3, 0);

        // Asynchronous reset mid-run
        wr(2'd2, 32'd9);
        wr(2'd0, 32'h1);
        tick(); tick();
        chk("rr_pre_en", 32'(en), 1);
        #2 rst = 0;
        #1;
        chk("rr_en", 32'(en), 0);
        chk("rr_busy", 32'(busy), 0);
        rd("rr_elapsed", 2'd3, 0);
        rd("rr_limit", 2'd2, 0);
        tick();
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_no_pe", 32'(perf_end), 0);
        end
        wr(2'd0, 32'h1);
        chk("rr_restart_ps", 32'(perf_start), 1);
        tick();
        chk("rr_restart_en", 32'(en), 1);
        wr(2'd0, 32'h2);
        chk("rr_restart_pe", 32'(perf_end), 1);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            spr_cs = 0; spr_write = 0;
            if (r < 8) begin
                spr_cs = 1; spr_write = 1; spr_addr = 2'd0; spr_dat_i = $urandom & 32'hF;
            end else if (r < 14) begin
                spr_cs = 1; spr_write = 1; spr_addr = 2'd2; spr_dat_i = $urandom_range(0, 12);
            end else if (r < 16) begin
                spr_cs = 1; spr_write = 1; spr_addr = 2'($urandom_range(1, 3)); spr_dat_i = $urandom;
                if (spr_addr == 2'd2) spr_addr = 2'd3;
            end else if (r < 45) begin
                spr_cs = 1; spr_addr = 2'($urandom_range(0, 3));
            end
            trig_start = ($urandom_range(0, 19) == 0);
            trig_end   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 0;
                tick();
                rst = 1;
            end else begin
                tick();
            end
        end
        spr_cs = 0; spr_write = 0; trig_start = 0; trig_end = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
